// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt type codes, the kernel/user
// execution state and the default OS entry vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        INT_NONE  = 2'd0,
        INT_TIMER = 2'd1,
        INT_KBD   = 2'd2,
        INT_HALT  = 2'd3
    } int_type_e;

    typedef enum logic {
        KERNEL = 1'b0,
        USER   = 1'b1
    } exec_state_e;

    localparam logic [31:0] OS_VECTOR_DEFAULT = 32'd0;

endpackage

// File: rtl/sincronizador_borda.sv
// Synchronizes an asynchronous level into the clock domain through
// STAGES flops and flags its rising edge for one cycle.
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset
//   async_in in   asynchronous level
//   rise     out  1 for one cycle after a synchronized 0->1 transition
module sincronizador_borda #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d    = '0;
        sync_d[0] = async_in;
        for (int unsigned i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/controlador_interrupcao.sv
// Interrupt controller: switches the CPU between kernel and user
// execution, owns the preemption timer, latches timer/keyboard requests,
// arbitrates them with user halt and redirects the PC to the OS vector.
//   clock, reset_n      clock and asynchronous active-low reset
//   set_clock, quantum  reload the preemption timer (0 disables it)
//   halt                halt decoded this cycle
//   os_jump_to          OS dispatches to the user process
//   cpu_stall           CPU frozen waiting for IN/OUT
//   keyboard_ready      asynchronous keyboard data-available level
//   pc_next             PC the CPU would load at this edge
//   irq_take            PC loads os_vector at this edge (combinational)
//   os_vector           OS entry address
//   saved_pc            resume PC of the interrupted process
//   interr_type         0 none, 1 timer, 2 keyboard, 3 process halt
//   in_kernel           1 while in kernel state (interrupts masked)
//   timer_count         current countdown value
module controlador_interrupcao
    import cpu_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  OS_VECTOR  = DATA_WIDTH'(OS_VECTOR_DEFAULT),
    parameter int unsigned            KBD_SYNC   = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_clock,
    input  logic [DATA_WIDTH-1:0] quantum,
    input  logic                  halt,
    input  logic                  os_jump_to,
    input  logic                  cpu_stall,
    input  logic                  keyboard_ready,
    input  logic [DATA_WIDTH-1:0] pc_next,
    output logic                  irq_take,
    output logic [DATA_WIDTH-1:0] os_vector,
    output logic [DATA_WIDTH-1:0] saved_pc,
    output logic [1:0]            interr_type,
    output logic                  in_kernel,
    output logic [DATA_WIDTH-1:0] timer_count
);

    exec_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] timer_count_q, timer_count_d;
    logic [DATA_WIDTH-1:0] saved_pc_q, saved_pc_d;
    int_type_e             interr_type_q, interr_type_d;
    logic                  timer_pending_q, timer_pending_d;
    logic                  kbd_pending_q, kbd_pending_d;

    logic      kbd_rise;
    logic      take;
    logic      tick;
    logic      expire;
    int_type_e winner;

    sincronizador_borda #(
        .STAGES(KBD_SYNC)
    ) u_sync_kbd (
        .clock   (clock),
        .reset_n (reset_n),
        .async_in(keyboard_ready),
        .rise    (kbd_rise)
    );

    always_comb begin
        state_d         = state_q;
        timer_count_d   = timer_count_q;
        saved_pc_d      = saved_pc_q;
        interr_type_d   = interr_type_q;
        timer_pending_d = timer_pending_q;
        kbd_pending_d   = kbd_pending_q;

        take = (state_q == USER) & ~cpu_stall
             & (halt | timer_pending_q | kbd_pending_q);

        if (halt)                 winner = INT_HALT;
        else if (timer_pending_q) winner = INT_TIMER;
        else                      winner = INT_KBD;

        // Reload has priority over counting, so an expiry in the reload
        // cycle is swallowed.
        tick   = (state_q == USER) & ~cpu_stall & (timer_count_q != '0);
        expire = ~set_clock & tick & (timer_count_q == DATA_WIDTH'(1));

        if (set_clock)  timer_count_d = quantum;
        else if (tick)  timer_count_d = timer_count_q - DATA_WIDTH'(1);

        // Clear first, then set, so a simultaneous set wins.
        if (take && winner == INT_TIMER) timer_pending_d = 1'b0;
        if (expire)                      timer_pending_d = 1'b1;
        if (take && winner == INT_KBD)   kbd_pending_d   = 1'b0;
        if (kbd_rise)                    kbd_pending_d   = 1'b1;

        if (take) begin
            saved_pc_d    = pc_next;
            interr_type_d = winner;
        end

        case (state_q)
            KERNEL:  if (os_jump_to) state_d = USER;
            USER:    if (take)       state_d = KERNEL;
            default: state_d = KERNEL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= KERNEL;
            timer_count_q   <= '0;
            saved_pc_q      <= '0;
            interr_type_q   <= INT_NONE;
            timer_pending_q <= 1'b0;
            kbd_pending_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_count_q   <= timer_count_d;
            saved_pc_q      <= saved_pc_d;
            interr_type_q   <= interr_type_d;
            timer_pending_q <= timer_pending_d;
            kbd_pending_q   <= kbd_pending_d;
        end
    end

    assign irq_take    = take;
    assign os_vector   = OS_VECTOR;
    assign saved_pc    = saved_pc_q;
    assign interr_type = interr_type_q;
    assign in_kernel   = (state_q == KERNEL);
    assign timer_count = timer_count_q;

endmodule

// File: tb/tb_controlador_interrupcao.sv
module tb_controlador_interrupcao;

    localparam int KS = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        set_clock, halt, os_jump_to, cpu_stall, keyboard_ready;
    logic [31:0] quantum, pc_next;
    logic        irq_take, in_kernel;
    logic [31:0] os_vector, saved_pc, timer_count;
    logic [1:0]  interr_type;

    int n_vec = 0;
    int n_bad = 0;

    controlador_interrupcao #(
        .DATA_WIDTH(32),
        .OS_VECTOR (32'd0),
        .KBD_SYNC  (KS)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .set_clock     (set_clock),
        .quantum       (quantum),
        .halt          (halt),
        .os_jump_to    (os_jump_to),
        .cpu_stall     (cpu_stall),
        .keyboard_ready(keyboard_ready),
        .pc_next       (pc_next),
        .irq_take      (irq_take),
        .os_vector     (os_vector),
        .saved_pc      (saved_pc),
        .interr_type   (interr_type),
        .in_kernel     (in_kernel),
        .timer_count   (timer_count)
    );

    always #5 clock = ~clock;

    // Reference model: execution mode, countdown, pending requests and the
    // recent history of sampled keyboard levels (newest at index 0).
    bit          m_user;
    int unsigned m_count;
    bit          m_tp, m_kp;
    logic [31:0] m_saved;
    int unsigned m_type;
    bit          m_hist[0:KS];

    task automatic model_reset();
        m_user = 0; m_count = 0; m_tp = 0; m_kp = 0; m_saved = '0; m_type = 0;
        for (int i = 0; i <= KS; i++) m_hist[i] = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic kern, input logic [1:0] typ,
                            input logic [31:0] sav, input logic [31:0] cnt);
        chk({tag, ".in_kernel"},   32'(in_kernel),   32'(kern));
        chk({tag, ".interr_type"}, 32'(interr_type), 32'(typ));
        chk({tag, ".saved_pc"},    saved_pc,         sav);
        chk({tag, ".timer_count"}, timer_count,      cnt);
    endtask

    // One clock cycle: inputs applied just after a rising edge, outputs
    // compared against the model before the next edge, then model advanced.
    task automatic do_cycle(input logic sc, input logic [31:0] q, input logic h,
                            input logic j, input logic st, input logic kb,
                            input logic [31:0] pc, output logic irq_seen);
        bit take, expire, rise;
        int unsigned win;
        set_clock = sc; quantum = q; halt = h; os_jump_to = j;
        cpu_stall = st; keyboard_ready = kb; pc_next = pc;
        #3;
        irq_seen = irq_take;

        rise   = m_hist[KS-1] && !m_hist[KS];
        take   = m_user && !st && (h || m_tp || m_kp);
        win    = h ? 3 : (m_tp ? 1 : 2);
        expire = !sc && m_user && !st && (m_count == 1);

        chk("m.irq_take",    32'(irq_take),    32'(take));
        chk("m.in_kernel",   32'(in_kernel),   32'(!m_user));
        chk("m.timer_count", timer_count,      m_count);
        chk("m.saved_pc",    saved_pc,         m_saved);
        chk("m.interr_type", 32'(interr_type), m_type);
        chk("m.os_vector",   os_vector,        32'd0);

        if (sc)                            m_count = q;
        else if (m_user && !st && m_count) m_count = m_count - 1;
        m_tp = (m_tp && !(take && win == 1)) || expire;
        m_kp = (m_kp && !(take && win == 2)) || rise;
        if (take) begin
            m_saved = pc;
            m_type  = win;
        end
        if (take)              m_user = 0;
        else if (!m_user && j) m_user = 1;
        for (int i = KS; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = kb;

        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        sc;
        logic [31:0] q;
        logic        h, j, st;
        logic [31:0] pc;
        int          reps;
        logic        e_irq;
        logic [31:0] e_cnt;
        logic        e_kern;
        logic [1:0]  e_typ;
        logic [31:0] e_sav;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic irq;
        bit kb_r;

        //         sc q   h j st pc      reps irq cnt kern typ sav
        tbl[0]  = '{1, 5, 0,0,0, 32'h0,   1,  0,  0,  1,  0, 32'h0};
        tbl[1]  = '{0, 0, 0,1,0, 32'h0,   1,  0,  5,  1,  0, 32'h0};
        tbl[2]  = '{0, 0, 0,0,0, 32'h100, 1,  0,  5,  0,  0, 32'h0};
        tbl[3]  = '{0, 0, 0,0,0, 32'h104, 1,  0,  4,  0,  0, 32'h0};
        tbl[4]  = '{0, 0, 0,0,0, 32'h108, 1,  0,  3,  0,  0, 32'h0};
        tbl[5]  = '{0, 0, 0,0,0, 32'h10c, 1,  0,  2,  0,  0, 32'h0};
        tbl[6]  = '{0, 0, 0,0,0, 32'h110, 1,  0,  1,  0,  0, 32'h0};
        tbl[7]  = '{0, 0, 0,0,0, 32'h124, 1,  1,  0,  0,  0, 32'h0};
        tbl[8]  = '{0, 0, 1,0,0, 32'h0,   1,  0,  0,  1,  1, 32'h124};
        tbl[9]  = '{1, 3, 0,0,0, 32'h0,   1,  0,  0,  1,  1, 32'h124};
        tbl[10] = '{0, 0, 0,1,0, 32'h0,   1,  0,  3,  1,  1, 32'h124};
        tbl[11] = '{0, 0, 0,0,1, 32'h0,  10,  0,  3,  0,  1, 32'h124};
        tbl[12] = '{0, 0, 0,0,0, 32'h0,   1,  0,  3,  0,  1, 32'h124};
        tbl[13] = '{0, 0, 0,0,0, 32'h0,   1,  0,  2,  0,  1, 32'h124};
        tbl[14] = '{0, 0, 0,0,0, 32'h0,   1,  0,  1,  0,  1, 32'h124};
        tbl[15] = '{0, 0, 0,0,1, 32'h0,   2,  0,  0,  0,  1, 32'h124};
        tbl[16] = '{0, 0, 0,0,0, 32'h200, 1,  1,  0,  0,  1, 32'h124};
        tbl[17] = '{0, 0, 0,0,0, 32'h0,   1,  0,  0,  1,  1, 32'h200};

        reset_n = 1'b0;
        set_clock = 0; quantum = 0; halt = 0; os_jump_to = 0;
        cpu_stall = 0; keyboard_ready = 0; pc_next = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset.irq_take", 32'(irq_take), 32'd0);
        chk_regs("reset", 1'b1, 2'd0, 32'h0, 32'h0);
        reset_n = 1'b1;

        // Table: timer countdown/expiry and stall freezing.
        for (int r = 0; r < 18; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                chk_regs($sformatf("tbl%0d", r), tbl[r].e_kern, tbl[r].e_typ,
                         tbl[r].e_sav, tbl[r].e_cnt);
                do_cycle(tbl[r].sc, tbl[r].q, tbl[r].h, tbl[r].j, tbl[r].st,
                         1'b0, tbl[r].pc, irq);
                chk($sformatf("tbl%0d.irq_take", r), 32'(irq), 32'(tbl[r].e_irq));
            end
        end

        // Keyboard edge in KERNEL is held until the first USER cycle.
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 0, 0, 0, 0, 1, 32'h0, irq);
            chk("kbd.kernel_masked", 32'(irq), 32'd0);
        end
        do_cycle(0, 0, 0, 1, 0, 1, 32'h0, irq);
        do_cycle(0, 0, 0, 0, 0, 1, 32'h300, irq);
        chk("kbd.first_user", 32'(irq), 32'd1);
        chk_regs("kbd.after", 1'b1, 2'd2, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 0, 0, 32'h0, irq);

        // Timer expiry and keyboard request land together: timer first.
        do_cycle(1, 2, 0, 0, 0, 0, 32'h0, irq);
        do_cycle(0, 0, 0, 1, 0, 1, 32'h0, irq);
        do_cycle(0, 0, 0, 0, 0, 1, 32'h0, irq);
        chk("both.cnt2", 32'(irq), 32'd0);
        do_cycle(0, 0, 0, 0, 0, 1, 32'h0, irq);
        chk("both.cnt1", 32'(irq), 32'd0);
        do_cycle(0, 0, 0, 0, 0, 1, 32'h410, irq);
        chk("both.take1", 32'(irq), 32'd1);
        chk_regs("both.t1", 1'b1, 2'd1, 32'h410, 32'h0);
        do_cycle(0, 0, 0, 1, 0, 1, 32'h0, irq);
        do_cycle(0, 0, 0, 0, 0, 0, 32'h500, irq);
        chk("both.take2", 32'(irq), 32'd1);
        chk_regs("both.t2", 1'b1, 2'd2, 32'h500, 32'h0);

        // Halt beats a pending timer, which stays pending.
        do_cycle(1, 1, 0, 0, 0, 0, 32'h0, irq);
        do_cycle(0, 0, 0, 1, 0, 0, 32'h0, irq);
        do_cycle(0, 0, 0, 0, 0, 0, 32'h3c, irq);
        chk("halt.pre", 32'(irq), 32'd0);
        do_cycle(0, 0, 1, 0, 0, 0, 32'h40, irq);
        chk("halt.take", 32'(irq), 32'd1);
        chk_regs("halt.after", 1'b1, 2'd3, 32'h40, 32'h0);
        do_cycle(0, 0, 0, 1, 0, 0, 32'h0, irq);
        do_cycle(0, 0, 0, 0, 0, 0, 32'h44, irq);
        chk("halt.timer_left", 32'(irq), 32'd1);
        chk_regs("halt.timer", 1'b1, 2'd1, 32'h44, 32'h0);

        // Reload in the 1->0 cycle suppresses the expiry.
        do_cycle(1, 2, 0, 0, 0, 0, 32'h0, irq);
        do_cycle(0, 0, 0, 1, 0, 0, 32'h0, irq);
        do_cycle(0, 0, 0, 0, 0, 0, 32'h0, irq);
        do_cycle(1, 7, 0, 0, 0, 0, 32'h0, irq);
        chk("reload.at1", 32'(irq), 32'd0);
        chk_regs("reload", 1'b0, 2'd1, 32'h44, 32'd7);
        do_cycle(0, 0, 0, 0, 0, 0, 32'h0, irq);
        chk("reload.noirq", 32'(irq), 32'd0);

        // Asynchronous reset mid-countdown.
        reset_n = 1'b0;
        #1;
        chk("areset.irq_take", 32'(irq_take), 32'd0);
        chk_regs("areset", 1'b1, 2'd0, 32'h0, 32'h0);
        model_reset();
        #1;
        reset_n = 1'b1;

        // Randomized traffic against the model.
        kb_r = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(9) == 0) kb_r = !kb_r;
            do_cycle($urandom_range(7) == 0, $urandom_range(6),
                     $urandom_range(19) == 0, $urandom_range(5) == 0,
                     $urandom_range(4) == 0, kb_r, $urandom, irq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/controlador_interrupcao.md
Name: controlador_interrupcao

Overview:
Sequences the processor between OS (kernel) and user-process execution.
- Owns the preemption timer loaded by set_interr_timer.
- Latches timer, keyboard and user-halt interrupt requests, arbitrates them by priority and forces the PC to the OS vector at an instruction boundary.
- Holds the interrupted PC and the interrupt type, read back by get_pc and get_interr_type.
- Sits beside the control unit, fed by its set_clock, halt, os_jump_to and stall-related signals, and drives the PC-select mux.

Parameters:
DATA_WIDTH, 32, width of quantum value and saved PC
OS_VECTOR, 32'd0, address the PC is forced to on interrupt entry
KBD_SYNC, 2, synchronizer stages for keyboard_ready

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
set_clock  in  1  set_interr_timer decoded this cycle
quantum  in  DATA_WIDTH  timer reload value (rs), 0 = timer disabled
halt  in  1  halt decoded this cycle
os_jump_to  in  1  OS dispatches to user process this cycle
cpu_stall  in  1  CPU frozen (enable_clock != 1, waiting for IN/OUT button)
keyboard_ready  in  1  asynchronous level from keyboard, data available
pc_next  in  DATA_WIDTH  PC the CPU would load at this edge
irq_take  out  1  combinational: PC must load os_vector at this edge
os_vector  out  DATA_WIDTH  constant OS_VECTOR
saved_pc  out  DATA_WIDTH  PC to resume the interrupted process
interr_type  out  2  0 none, 1 timer, 2 keyboard, 3 process halt
in_kernel  out  1  1 while in KERNEL state (interrupts masked)
timer_count  out  DATA_WIDTH  current countdown value (debug/LCD)

Behaviour:
Reset (async, reset_n=0):
- state=KERNEL; saved_pc=0; interr_type=0; timer_count=0.
- All pending flags=0; synchronizer=0.
- irq_take=0 while in reset.

FSM states: KERNEL, USER.
- KERNEL -> USER on os_jump_to=1. USER is entered at that edge.
- USER -> KERNEL at any edge where irq_take=1.
- os_jump_to in USER is ignored.
- halt in KERNEL is ignored (CPU stops).

Timer:
- set_clock=1: timer_count<=quantum in either state. This overrides the decrement and any expiry in the same cycle; timer_pending is not set that cycle.
- Decrements by 1 only when state=USER, cpu_stall=0 and timer_count!=0.
- Transition 1->0 sets timer_pending. The counter then stays 0 (no wrap) until reloaded.
- quantum=0 never raises an interrupt.

Keyboard:
- keyboard_ready passes through a KBD_SYNC-stage synchronizer.
- A rising edge of the synchronized signal sets kbd_pending in any state, so requests arriving in KERNEL are held.
- Level-high without a new edge does not re-trigger.

User halt:
- halt=1 in USER is a request with combinational effect in the same cycle. It is not latched.

irq_take = (state==USER) & !cpu_stall & (halt | timer_pending | kbd_pending).

Priority: halt(3) > timer(1) > keyboard(2).

At an edge with irq_take=1:
- saved_pc<=pc_next; interr_type<=code of the winner; the winner's pending flag is cleared; the others stay pending.
- The current instruction's register and memory writes complete normally.

A request arriving while cpu_stall=1 waits until the stall ends. It never aborts IN/OUT.

A request pending on return to USER is taken on the first non-stalled USER cycle. This may be the cycle right after os_jump_to.

A set and a clear of the same pending flag in one cycle: set wins.

Decomposition:
- Shared package cpu_pkg:
  - interrupt type codes INT_NONE=0, INT_TIMER=1, INT_KBD=2, INT_HALT=3.
  - state encoding.
  - OS_VECTOR default.
- One sub-module: sincronizador_borda (KBD_SYNC flops plus rising-edge detector), reused by future I/O sources.
- Everything else stays in one module.

Test Plan:
- Reset, then os_jump_to with quantum=5 set one cycle earlier -> USER. timer_count runs 5,4,3,2,1,0. irq_take=1 on the cycle after reaching 0. saved_pc=pc_next at that edge, interr_type=1, in_kernel=1.
- cpu_stall=1 held 10 cycles in USER with timer_count=3 -> count frozen at 3, no irq. After the stall releases, expiry occurs 3 cycles later.
- keyboard_ready rises while in KERNEL -> no irq_take. After os_jump_to, irq_take=1 on the first USER cycle, interr_type=2.
- Timer expiry and keyboard edge in the same cycle -> first take type 1, keyboard still pending. After os_jump_to, the next take is type 2.
- halt=1 in USER with pc_next=0x40 and timer pending -> interr_type=3, saved_pc=0x40, timer_pending still 1.
- set_clock with quantum=7 in the cycle timer hits 1->0 -> timer_count=7, no interrupt. reset_n pulsed low mid-countdown -> everything returns to reset values immediately, state KERNEL.
